// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXECUTE/MEM/WRITEBACK over one unified memory port.
// Optional cycle/instret counters are enabled by defining MULTICYCLE_PERF_CNT_EN.
package defines;
    typedef enum logic [2:0] {
        ALUOP_MEM_ADDR    = 3'd0,
        ALUOP_BRANCH      = 3'd1,
        ALUOP_RTYPE       = 3'd2,
        ALUOP_ITYPE_ARITH = 3'd3,
        ALUOP_JUMP        = 3'd4,
        ALUOP_LUI         = 3'd5
    } alu_op_class_e;

    typedef enum logic [2:0] {
        IMM_TYPE_R = 3'd0,
        IMM_TYPE_I = 3'd1,
        IMM_TYPE_S = 3'd2,
        IMM_TYPE_B = 3'd3,
        IMM_TYPE_U = 3'd4,
        IMM_TYPE_J = 3'd5
    } imm_sel_e;

    localparam logic [6:0] OPCODE_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPCODE_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
endpackage

module multicycle_control_unit
    import defines::*;
#(
    parameter int unsigned MEM_TIMEOUT = 0
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [6:0]    opcode_i,
    input  logic          branch_taken_i,
    input  logic          mem_ready_i,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic          addr_sel_o,
    output logic          ir_we_o,
    output logic          pc_we_o,
    output logic          pc_src_o,
    output logic          reg_we_o,
    output logic [1:0]    wb_sel_o,
    output logic          ALUSrc_o,
    output alu_op_class_e ALUOp_o,
    output imm_sel_e      ImmSel_o,
    output logic          instr_retired_o,
    output logic          halted_o
`ifdef MULTICYCLE_PERF_CNT_EN
    ,
    output logic [31:0]   cycle_cnt_o,
    output logic [31:0]   instret_cnt_o
`endif
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CLS_ILLEGAL = 3'd0,
        CLS_RTYPE   = 3'd1,
        CLS_ITYPE   = 3'd2,
        CLS_LOAD    = 3'd3,
        CLS_STORE   = 3'd4,
        CLS_BRANCH  = 3'd5,
        CLS_JAL     = 3'd6,
        CLS_LUI     = 3'd7
    } cls_e;

    function automatic cls_e decode_class(input logic [6:0] opc);
        cls_e c;
        case (opc)
            OPCODE_RTYPE:  c = CLS_RTYPE;
            OPCODE_ITYPE:  c = CLS_ITYPE;
            OPCODE_LOAD:   c = CLS_LOAD;
            OPCODE_STORE:  c = CLS_STORE;
            OPCODE_BRANCH: c = CLS_BRANCH;
            OPCODE_JAL:    c = CLS_JAL;
            OPCODE_LUI:    c = CLS_LUI;
            default:       c = CLS_ILLEGAL;
        endcase
        return c;
    endfunction

    function automatic imm_sel_e imm_for_class(input cls_e c);
        imm_sel_e s;
        case (c)
            CLS_ITYPE, CLS_LOAD: s = IMM_TYPE_I;
            CLS_STORE:           s = IMM_TYPE_S;
            CLS_BRANCH:          s = IMM_TYPE_B;
            CLS_JAL:             s = IMM_TYPE_J;
            CLS_LUI:             s = IMM_TYPE_U;
            default:             s = IMM_TYPE_R;
        endcase
        return s;
    endfunction

    state_e        state_q, state_d;
    cls_e          cls_q, cls_d;
    logic [7:0]    wait_q, wait_d;

    cls_e          opc_cls_s;
    logic          timeout_s;
    logic          mem_req_s, mem_we_s, addr_sel_s, ir_we_s, pc_we_s, pc_src_s, reg_we_s;
    logic [1:0]    wb_sel_s;
    logic          alu_src_s, retired_s, halted_s;
    alu_op_class_e alu_op_s;
    imm_sel_e      imm_sel_s;

    // Next-state and per-state control decode.
    always_comb begin
        state_d    = state_q;
        opc_cls_s  = decode_class(opcode_i);
        cls_d      = cls_q;
        timeout_s  = (MEM_TIMEOUT != 32'd0) && (wait_q == MEM_TIMEOUT[7:0]);
        mem_req_s  = 1'b0;
        mem_we_s   = 1'b0;
        addr_sel_s = 1'b0;
        ir_we_s    = 1'b0;
        pc_we_s    = 1'b0;
        pc_src_s   = 1'b0;
        reg_we_s   = 1'b0;
        wb_sel_s   = 2'd0;
        alu_src_s  = 1'b0;
        retired_s  = 1'b0;
        halted_s   = 1'b0;
        alu_op_s   = ALUOP_MEM_ADDR;
        imm_sel_s  = IMM_TYPE_R;

        case (state_q)
            S_FETCH: begin
                mem_req_s = 1'b1;
                if (mem_ready_i) begin
                    ir_we_s = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout_s) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                imm_sel_s = imm_for_class(opc_cls_s);
                cls_d     = opc_cls_s;
                if (opc_cls_s == CLS_ILLEGAL) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                imm_sel_s = imm_for_class(cls_q);
                case (cls_q)
                    CLS_RTYPE: begin
                        alu_op_s = ALUOP_RTYPE;
                        state_d  = S_WRITEBACK;
                    end
                    CLS_ITYPE: begin
                        alu_op_s  = ALUOP_ITYPE_ARITH;
                        alu_src_s = 1'b1;
                        state_d   = S_WRITEBACK;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        alu_op_s  = ALUOP_MEM_ADDR;
                        alu_src_s = 1'b1;
                        state_d   = S_MEM;
                    end
                    CLS_BRANCH: begin
                        alu_op_s  = ALUOP_BRANCH;
                        pc_we_s   = 1'b1;
                        pc_src_s  = branch_taken_i;
                        retired_s = 1'b1;
                        state_d   = S_FETCH;
                    end
                    CLS_JAL: begin
                        alu_op_s = ALUOP_JUMP;
                        state_d  = S_WRITEBACK;
                    end
                    CLS_LUI: begin
                        alu_op_s  = ALUOP_LUI;
                        alu_src_s = 1'b1;
                        state_d   = S_WRITEBACK;
                    end
                    default: state_d = S_HALT;
                endcase
            end
            S_MEM: begin
                imm_sel_s  = imm_for_class(cls_q);
                mem_req_s  = 1'b1;
                addr_sel_s = 1'b1;
                mem_we_s   = (cls_q == CLS_STORE);
                if (mem_ready_i) begin
                    if (cls_q == CLS_STORE) begin
                        pc_we_s   = 1'b1;
                        retired_s = 1'b1;
                        state_d   = S_FETCH;
                    end else begin
                        state_d   = S_WRITEBACK;
                    end
                end else if (timeout_s) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_MEM;
                end
            end
            S_WRITEBACK: begin
                imm_sel_s = imm_for_class(cls_q);
                reg_we_s  = 1'b1;
                pc_we_s   = 1'b1;
                retired_s = 1'b1;
                pc_src_s  = (cls_q == CLS_JAL);
                if (cls_q == CLS_LOAD) begin
                    wb_sel_s = 2'd1;
                end else if (cls_q == CLS_JAL) begin
                    wb_sel_s = 2'd2;
                end else begin
                    wb_sel_s = 2'd0;
                end
                state_d = S_FETCH;
            end
            S_HALT: begin
                halted_s = 1'b1;
                state_d  = S_HALT;
            end
            default: state_d = S_HALT;
        endcase
    end

    // Wait counter restarts whenever a new memory access begins.
    always_comb begin
        if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM))) begin
            wait_d = 8'd0;
        end else if (mem_req_s && !mem_ready_i) begin
            wait_d = wait_q + 8'd1;
        end else begin
            wait_d = wait_q;
        end
    end

    // State, latched instruction class and wait counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_FETCH;
            cls_q   <= CLS_ILLEGAL;
            wait_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            wait_q  <= wait_d;
        end
    end

    // Outputs are forced low while reset is held so an in-flight request drops at once.
    always_comb begin
        if (!rst_ni) begin
            mem_req_o       = 1'b0;
            mem_we_o        = 1'b0;
            addr_sel_o      = 1'b0;
            ir_we_o         = 1'b0;
            pc_we_o         = 1'b0;
            pc_src_o        = 1'b0;
            reg_we_o        = 1'b0;
            wb_sel_o        = 2'd0;
            ALUSrc_o        = 1'b0;
            ALUOp_o         = ALUOP_MEM_ADDR;
            ImmSel_o        = IMM_TYPE_R;
            instr_retired_o = 1'b0;
            halted_o        = 1'b0;
        end else begin
            mem_req_o       = mem_req_s;
            mem_we_o        = mem_we_s;
            addr_sel_o      = addr_sel_s;
            ir_we_o         = ir_we_s;
            pc_we_o         = pc_we_s;
            pc_src_o        = pc_src_s;
            reg_we_o        = reg_we_s;
            wb_sel_o        = wb_sel_s;
            ALUSrc_o        = alu_src_s;
            ALUOp_o         = alu_op_s;
            ImmSel_o        = imm_sel_s;
            instr_retired_o = retired_s;
            halted_o        = halted_s;
        end
    end

`ifdef MULTICYCLE_PERF_CNT_EN
    logic [31:0] cycle_cnt_q, instret_cnt_q;

    // Free-running performance counters, frozen once halted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cycle_cnt_q   <= 32'd0;
            instret_cnt_q <= 32'd0;
        end else begin
            if (state_q != S_HALT) begin
                cycle_cnt_q <= cycle_cnt_q + 32'd1;
            end else begin
                cycle_cnt_q <= cycle_cnt_q;
            end
            if (retired_s) begin
                instret_cnt_q <= instret_cnt_q + 32'd1;
            end else begin
                instret_cnt_q <= instret_cnt_q;
            end
        end
    end

    assign cycle_cnt_o   = cycle_cnt_q;
    assign instret_cnt_o = instret_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed table-driven bench for multicycle_control_unit plus hand-written halt/reset/timeout sequences.
module tb_multicycle_control_unit;
    import defines::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, ready, taken;
    logic [6:0]    opcode;
    logic          mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, reg_we, alu_src, retired, halted;
    logic [1:0]    wb_sel;
    alu_op_class_e aluop;
    imm_sel_e      immsel;

    logic          rst2_n, ready2;
    logic          t_mem_req, t_mem_we, t_addr_sel, t_ir_we, t_pc_we, t_pc_src, t_reg_we, t_alu_src, t_retired, t_halted;
    logic [1:0]    t_wb_sel;
    alu_op_class_e t_aluop;
    imm_sel_e      t_immsel;
`ifdef MULTICYCLE_PERF_CNT_EN
    logic [31:0]   cycle_cnt, instret_cnt, t_cycle_cnt, t_instret_cnt;
`endif

    multicycle_control_unit dut (
        .clk_i(clk), .rst_ni(rst_n), .opcode_i(opcode), .branch_taken_i(taken), .mem_ready_i(ready),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .addr_sel_o(addr_sel), .ir_we_o(ir_we), .pc_we_o(pc_we),
        .pc_src_o(pc_src), .reg_we_o(reg_we), .wb_sel_o(wb_sel), .ALUSrc_o(alu_src), .ALUOp_o(aluop),
        .ImmSel_o(immsel), .instr_retired_o(retired), .halted_o(halted)
`ifdef MULTICYCLE_PERF_CNT_EN
        , .cycle_cnt_o(cycle_cnt), .instret_cnt_o(instret_cnt)
`endif
    );

    multicycle_control_unit #(.MEM_TIMEOUT(4)) dut_to (
        .clk_i(clk), .rst_ni(rst2_n), .opcode_i(OPCODE_RTYPE), .branch_taken_i(1'b0), .mem_ready_i(ready2),
        .mem_req_o(t_mem_req), .mem_we_o(t_mem_we), .addr_sel_o(t_addr_sel), .ir_we_o(t_ir_we), .pc_we_o(t_pc_we),
        .pc_src_o(t_pc_src), .reg_we_o(t_reg_we), .wb_sel_o(t_wb_sel), .ALUSrc_o(t_alu_src), .ALUOp_o(t_aluop),
        .ImmSel_o(t_immsel), .instr_retired_o(t_retired), .halted_o(t_halted)
`ifdef MULTICYCLE_PERF_CNT_EN
        , .cycle_cnt_o(t_cycle_cnt), .instret_cnt_o(t_instret_cnt)
`endif
    );

    typedef struct {
        string         name;
        logic [6:0]    opc;
        logic          tk;
        int            fw;
        int            mw;
        int            cycles;
        int            wb;
        int            psrc;
        int            n_reg;
        int            n_mwe;
        int            n_mcyc;
        imm_sel_e      imm;
        alu_op_class_e alu;
        int            src;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs[NV];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int fl, ml, cyc, n_reg, n_mwe, n_mcyc, n_ir, n_ret, bad;
        int g_imm, g_alu, g_src, g_wb, g_psrc, g_pcwe;
        bit done;
        fl = v.fw; ml = v.mw; cyc = 0; done = 1'b0;
        n_reg = 0; n_mwe = 0; n_mcyc = 0; n_ir = 0; n_ret = 0; bad = 0;
        g_imm = -1; g_alu = -1; g_src = -1; g_wb = -1; g_psrc = -1; g_pcwe = -1;
        opcode = v.opc;
        taken  = v.tk;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (mem_req && !addr_sel) begin
                ready = (fl == 0);
                if (fl > 0) fl--;
            end else if (mem_req && addr_sel) begin
                ready = (ml == 0);
                if (ml > 0) ml--;
            end else begin
                ready = 1'b0;
            end
            #1;
            if (ir_we) n_ir++;
            if (reg_we) n_reg++;
            if (mem_we && mem_req) n_mwe++;
            if (mem_we && !mem_req) bad++;
            if (mem_req && addr_sel) n_mcyc++;
            if (cyc == v.fw + 2) g_imm = int'(immsel);
            if (cyc == v.fw + 3) begin
                g_alu = int'(aluop);
                g_src = int'(alu_src);
            end
            if (halted) done = 1'b1;
            if (retired) begin
                n_ret++;
                g_wb   = int'(wb_sel);
                g_psrc = int'(pc_src);
                g_pcwe = int'(pc_we);
                done   = 1'b1;
            end
        end
        chk({v.name, "_cycles"}, cyc, v.cycles);
        chk({v.name, "_retired"}, n_ret, 1);
        chk({v.name, "_ir_we"}, n_ir, 1);
        chk({v.name, "_pc_we"}, g_pcwe, 1);
        chk({v.name, "_wb_sel"}, g_wb, v.wb);
        chk({v.name, "_pc_src"}, g_psrc, v.psrc);
        chk({v.name, "_reg_we"}, n_reg, v.n_reg);
        chk({v.name, "_mem_we"}, n_mwe, v.n_mwe);
        chk({v.name, "_mem_cycles"}, n_mcyc, v.n_mcyc);
        chk({v.name, "_we_without_req"}, bad, 0);
        chk({v.name, "_imm_sel"}, g_imm, int'(v.imm));
        chk({v.name, "_alu_op"}, g_alu, int'(v.alu));
        chk({v.name, "_alu_src"}, g_src, v.src);
        @(negedge clk);
        ready = 1'b0;
        #1;
        chk({v.name, "_back_in_fetch"}, int'({mem_req, addr_sel, halted}), 4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, hk;
        vecs[0]  = '{"rtype",    OPCODE_RTYPE,  1'b0, 0, 0, 4, 0, 0, 1, 0, 0, IMM_TYPE_R, ALUOP_RTYPE,       0};
        vecs[1]  = '{"itype",    OPCODE_ITYPE,  1'b0, 1, 0, 5, 0, 0, 1, 0, 0, IMM_TYPE_I, ALUOP_ITYPE_ARITH, 1};
        vecs[2]  = '{"load_w2",  OPCODE_LOAD,   1'b0, 0, 2, 7, 1, 0, 1, 0, 3, IMM_TYPE_I, ALUOP_MEM_ADDR,    1};
        vecs[3]  = '{"store",    OPCODE_STORE,  1'b0, 0, 0, 4, 0, 0, 0, 1, 1, IMM_TYPE_S, ALUOP_MEM_ADDR,    1};
        vecs[4]  = '{"br_taken", OPCODE_BRANCH, 1'b1, 0, 0, 3, 0, 1, 0, 0, 0, IMM_TYPE_B, ALUOP_BRANCH,      0};
        vecs[5]  = '{"br_not",   OPCODE_BRANCH, 1'b0, 2, 0, 5, 0, 0, 0, 0, 0, IMM_TYPE_B, ALUOP_BRANCH,      0};
        vecs[6]  = '{"jal",      OPCODE_JAL,    1'b0, 0, 0, 4, 2, 1, 1, 0, 0, IMM_TYPE_J, ALUOP_JUMP,        0};
        vecs[7]  = '{"lui_fw3",  OPCODE_LUI,    1'b1, 3, 0, 7, 0, 0, 1, 0, 0, IMM_TYPE_U, ALUOP_LUI,         1};
        vecs[8]  = '{"store_w3", OPCODE_STORE,  1'b1, 1, 3, 8, 0, 0, 0, 4, 4, IMM_TYPE_S, ALUOP_MEM_ADDR,    1};
        vecs[9]  = '{"load",     OPCODE_LOAD,   1'b0, 0, 0, 5, 1, 0, 1, 0, 1, IMM_TYPE_I, ALUOP_MEM_ADDR,    1};
        vecs[10] = '{"rtype_w10",OPCODE_RTYPE,  1'b0, 10, 0, 14, 0, 0, 1, 0, 0, IMM_TYPE_R, ALUOP_RTYPE,     0};

        rst_n = 1'b0; rst2_n = 1'b0; ready = 1'b1; ready2 = 1'b0; taken = 1'b0; opcode = OPCODE_RTYPE;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs", int'({mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, reg_we, wb_sel,
                                   alu_src, aluop, immsel, retired, halted}), 0);
        ready = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("fetch_after_reset", int'({mem_req, addr_sel, mem_we}), 4);

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i]);
        end
`ifdef MULTICYCLE_PERF_CNT_EN
        chk("instret_cnt", int'(instret_cnt), NV);
`endif

        opcode = 7'b0000000;
        @(negedge clk); ready = 1'b1; #1;
        chk("illegal_fetch_ir_we", int'(ir_we), 1);
        @(negedge clk); ready = 1'b0; #1;
        chk("illegal_decode_not_halted", int'(halted), 0);
        @(negedge clk); #1;
        chk("illegal_halted", int'(halted), 1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); ready = 1'b1; #1;
            if (!halted || mem_req || retired || ir_we || pc_we || reg_we) bad++;
        end
        chk("halt_hold_20", bad, 0);

        rst_n = 1'b0; #2; rst_n = 1'b1;
        opcode = OPCODE_LOAD;
        @(negedge clk); ready = 1'b1;
        @(negedge clk); ready = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        chk("mid_mem_req", int'({mem_req, addr_sel}), 3);
        #1; rst_n = 1'b0; #1;
        chk("async_reset_drop", int'({mem_req, mem_we, addr_sel, ir_we, pc_we, reg_we, retired, halted}), 0);
        @(negedge clk); #1; rst_n = 1'b1; #1;
        chk("fetch_restart", int'({mem_req, addr_sel, halted}), 4);
        run_vec(vecs[0]);

        @(negedge clk); rst2_n = 1'b1;
        hk = 0; bad = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (t_halted && hk == 0) hk = k;
            if (!t_halted && !t_mem_req) bad++;
            if (t_halted && (t_mem_req || t_retired)) bad++;
        end
        chk("timeout_halt_cycle", hk, 5);
        chk("timeout_req_behaviour", bad, 0);
`ifdef MULTICYCLE_PERF_CNT_EN
        chk("timeout_instret", int'(t_instret_cnt), 0);
        chk("timeout_cycle_frozen", int'(t_cycle_cnt), 5);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

- Sequencing FSM for the multi-cycle RV32I core.
- Steps the shared datapath through FETCH/DECODE/EXECUTE/MEM/WRITEBACK using the opcode held in the instruction register.
- Arbitrates the single unified memory port between instruction fetch and data access.
- Drives the same decoded control classes (`alu_op_class_e`, `imm_sel_e`) from the `defines` package as the combinational main control.

## Interface
- `MEM_TIMEOUT`, default 0: max wait cycles for `mem_ready_i` per access; 0 disables the timeout. Range 0–255.
- `clk_i`  in  1  system clock, rising-edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `opcode_i`  in  7  opcode field of the IR output.
- `branch_taken_i`  in  1  comparator result from the ALU in EXECUTE.
- `mem_ready_i`  in  1  memory accepts/completes the current request this cycle.
- `mem_req_o`  out  1  memory request; held until `mem_ready_i`.
- `mem_we_o`  out  1  write strobe; valid only with `mem_req_o`.
- `addr_sel_o`  out  1  memory address select: 0 = PC, 1 = ALU result register.
- `ir_we_o`  out  1  instruction register load.
- `pc_we_o`  out  1  PC update.
- `pc_src_o`  out  1  PC source: 0 = PC+4, 1 = PC+imm.
- `reg_we_o`  out  1  register file write.
- `wb_sel_o`  out  2  writeback source: 0 = ALU, 1 = memory data, 2 = PC+4.
- `ALUSrc_o`  out  1  ALU operand B: 0 = rs2, 1 = immediate.
- `ALUOp_o`  out  `alu_op_class_e`  ALU operation class.
- `ImmSel_o`  out  `imm_sel_e`  immediate format.
- `instr_retired_o`  out  1  one-cycle pulse when an instruction completes.
- `halted_o`  out  1  sticky halt: illegal opcode or memory timeout.

## Operation
- States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT. Reset state is FETCH.
- **FETCH:** `mem_req_o`=1, `addr_sel_o`=0, `mem_we_o`=0.
  - On `mem_ready_i`: `ir_we_o`=1, go to DECODE.
  - Otherwise stay in FETCH, outputs unchanged.
- **DECODE:** one cycle.
  - `ImmSel_o` set from `opcode_i` (R→IMM_TYPE_R, LOAD/ITYPE→I, STORE→S, BRANCH→B, JAL→J, LUI→U).
  - Legal opcodes (RTYPE, LOAD, STORE, BRANCH, ITYPE, JAL, LUI) go to EXECUTE. Any other opcode goes to HALT.
- **EXECUTE:** `ALUOp_o` and `ALUSrc_o` per class (RTYPE: ALUOP_RTYPE/0; ITYPE: ALUOP_ITYPE_ARITH/1; LOAD/STORE: ALUOP_MEM_ADDR/1; BRANCH: ALUOP_BRANCH/0; JAL: ALUOP_JUMP/0; LUI: ALUOP_LUI/1).
  - LOAD/STORE go to MEM.
  - BRANCH: `pc_we_o`=1, `pc_src_o`=`branch_taken_i`, `instr_retired_o`=1, go to FETCH.
  - All other classes go to WRITEBACK.
- **MEM:** `mem_req_o`=1, `addr_sel_o`=1, `mem_we_o`=(STORE).
  - On `mem_ready_i`: a LOAD goes to WRITEBACK.
  - On `mem_ready_i`: a STORE asserts `pc_we_o`=1, `pc_src_o`=0, `instr_retired_o`=1 and goes to FETCH.
- **WRITEBACK:** `reg_we_o`=1, `pc_we_o`=1, `instr_retired_o`=1, go to FETCH.
  - `wb_sel_o`: 1 for LOAD, 2 for JAL, 0 otherwise.
  - `pc_src_o`: 1 for JAL, 0 otherwise.
- **HALT:** all strobes 0, `halted_o`=1. The FSM stays in HALT until reset.
- **Timeout** (`MEM_TIMEOUT`>0): an 8-bit wait counter clears on entry to FETCH or MEM and increments each cycle `mem_req_o`=1 and `mem_ready_i`=0. When the count reaches `MEM_TIMEOUT`, the FSM goes to HALT the next cycle and drops `mem_req_o`.
- Outputs depend on current state and latched opcode only; they never depend combinationally on `mem_ready_i`. The exceptions are the FETCH/MEM completion strobes (`ir_we_o`, `pc_we_o`, `instr_retired_o`).
- `opcode_i` is sampled in DECODE. It is stable from then until FETCH, because `ir_we_o` is 0 outside FETCH.

## Timing
- Reset: all outputs 0, `ALUOp_o`/`ImmSel_o` at enum value 0, `halted_o`=0, state FETCH, wait counter 0. Reset takes effect immediately.
- Reset asserted mid-access drops `mem_req_o` asynchronously. The in-flight memory access is abandoned.
- Zero-wait memory (`mem_ready_i`=1 in the request cycle), cycles per instruction:
  - BRANCH 3.
  - RTYPE/ITYPE/LUI/JAL/STORE 4.
  - LOAD 5.
- Each wait cycle adds 1 cycle.
- `mem_req_o` does not deassert between request and `mem_ready_i`. `addr_sel_o` and `mem_we_o` stay constant during that window.
- `instr_retired_o` is exactly one cycle per instruction and is never asserted in HALT.

## Configuration
- `MULTICYCLE_PERF_CNT_EN` defined: adds two output ports.
  - `cycle_cnt_o` (32): counts every cycle the FSM is not in HALT.
  - `instret_cnt_o` (32): counts `instr_retired_o` pulses.
  - Both reset to 0 and wrap modulo 2^32.
- `MULTICYCLE_PERF_CNT_EN` undefined: both ports and counters are absent. All other behaviour is identical.

## Test plan
- R-type, zero-wait memory: `opcode_i`=OPCODE_RTYPE, `mem_ready_i`=1.
  - `ir_we_o` in cycle 1.
  - `reg_we_o`=1, `wb_sel_o`=0, `pc_we_o`=1 in cycle 4.
  - `instr_retired_o` once in cycle 4, back in FETCH in cycle 5.
- LOAD with 2 wait states in MEM: `mem_req_o`=1 with `addr_sel_o`=1 for 3 cycles, then WRITEBACK with `wb_sel_o`=1. Total 7 cycles.
- STORE: `mem_we_o`=1 only in MEM, `reg_we_o` never asserted. Retires in 4 cycles.
- BRANCH:
  - `branch_taken_i`=1: `pc_src_o`=1 with `pc_we_o` in cycle 3.
  - `branch_taken_i`=0: `pc_src_o`=0.
  - JAL: `wb_sel_o`=2, `pc_src_o`=1 in WRITEBACK.
- Illegal opcode 7'b0000000: HALT after DECODE, `halted_o`=1 and held for 20 cycles.
  - `rst_ni` low mid-MEM: outputs 0 immediately, fetch restarts after release.
- `MEM_TIMEOUT`=4, `mem_ready_i` tied 0: `halted_o` rises 5 cycles after reset release.
  - With `MULTICYCLE_PERF_CNT_EN`: `instret_cnt_o`=0 and `cycle_cnt_o` frozen.
